// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812B strip driver.
//   - ws_state_e   : frame sequencer states
//   - *_LSB, CH_W  : G/R/B field positions inside a 24-bit GRB pixel word
//   - DEF_*        : default bit/latch timing for a 12 MHz clock
//   - dim_pixel()  : per-channel brightness right-shift
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StShift,
        StLatch
    } ws_state_e;

    localparam int unsigned PIX_W        = 24;
    localparam int unsigned CH_W         = 8;
    localparam int unsigned G_LSB        = 16;
    localparam int unsigned R_LSB        = 8;
    localparam int unsigned B_LSB        = 0;
    localparam int unsigned BITS_PER_PIX = PIX_W;

    // 12 MHz defaults: 16 clocks = 1333 ns per bit, 3600 clocks = 300 us latch.
    localparam int unsigned DEF_NUM_LEDS  = 60;
    localparam int unsigned DEF_T_BIT     = 16;
    localparam int unsigned DEF_T0H       = 4;
    localparam int unsigned DEF_T1H       = 12;
    localparam int unsigned DEF_RESET_CYC = 3600;

    function automatic logic [PIX_W-1:0] dim_pixel(input logic [PIX_W-1:0] pix,
                                                   input logic [2:0]       shift);
        logic [CH_W-1:0] g, r, b;
        g = pix[G_LSB +: CH_W] >> shift;
        r = pix[R_LSB +: CH_W] >> shift;
        b = pix[B_LSB +: CH_W] >> shift;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// pixel_ram: DEPTH x DW frame buffer, one synchronous write port and one
// synchronous read port. No reset; contents persist across driver resets.
//   clk               : clock
//   wr_en/wr_addr/wr_data : write port (caller guarantees wr_addr < DEPTH)
//   rd_en/rd_addr     : read request, data registered on the same edge
//   rd_data           : last read word, held while rd_en is low
module pixel_ram #(
    parameter int unsigned DEPTH = 60,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ws2812_strip_driver.sv
// ws2812_strip_driver: serialises a GRB frame buffer onto a WS2812B data line.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : pixel write port (out-of-range addresses ignored)
//   dim               : per-channel right-shift, sampled when a frame starts
//   start             : single-cycle frame request (ignored while busy)
//   auto_refresh      : repeat frames back to back while high
//   led               : registered WS2812B data line
//   busy              : frame in progress
//   frame_done        : one-cycle pulse at the end of the latch gap
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = DEF_NUM_LEDS,
    parameter int unsigned T_BIT     = DEF_T_BIT,
    parameter int unsigned T0H       = DEF_T0H,
    parameter int unsigned T1H       = DEF_T1H,
    parameter int unsigned RESET_CYC = DEF_RESET_CYC,
    parameter int unsigned AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [2:0]       dim,
    input  logic             start,
    input  logic             auto_refresh,
    output logic             led,
    output logic             busy,
    output logic             frame_done
);

    if (T0H < 1 || T0H >= T1H || T1H >= T_BIT || NUM_LEDS < 1 || RESET_CYC < 1)
    begin : g_param_check
        $error("ws2812_strip_driver: illegal timing or size parameters");
    end

    localparam int unsigned PHW = $clog2(T_BIT);
    localparam int unsigned BIW = $clog2(BITS_PER_PIX);
    localparam int unsigned LTW = $clog2(RESET_CYC + 1);

    localparam logic [PHW-1:0] T0H_C      = PHW'(T0H);
    localparam logic [PHW-1:0] T1H_C      = PHW'(T1H);
    localparam logic [PHW-1:0] LAST_PHASE = PHW'(T_BIT - 1);
    localparam logic [BIW-1:0] LAST_BIT   = BIW'(BITS_PER_PIX - 1);
    localparam logic [AW-1:0]  LAST_PIX   = AW'(NUM_LEDS - 1);
    localparam logic [LTW-1:0] LAT_END    = LTW'(RESET_CYC - 1);
    localparam logic [LTW-1:0] LAT_PULSE  = LTW'(RESET_CYC);

    ws_state_e      state_q, state_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic [BIW-1:0] bit_q, bit_d;
    logic [AW-1:0]  pix_q, pix_d;
    logic [LTW-1:0] lat_q, lat_d;
    logic [2:0]     dim_q, dim_d;
    logic           led_q, led_d;
    logic           frame_done_q, frame_done_d;

    logic             wr_ok;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] cur_word;
    logic             cur_bit;
    logic [PHW-1:0]   thr;

    assign wr_ok = wr_en && (32'(wr_addr) < NUM_LEDS);

    pixel_ram #(
        .DEPTH (NUM_LEDS),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // rd_data only changes on the edge that starts a new pixel, so it can
    // serve directly as the shift word for the whole pixel.
    assign cur_word = dim_pixel(rd_data, dim_q);
    assign cur_bit  = cur_word[LAST_BIT - bit_q];
    assign thr      = cur_bit ? T1H_C : T0H_C;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        pix_d        = pix_q;
        lat_d        = lat_q;
        dim_d        = dim_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;

        unique case (state_q)
            StIdle: begin
                if (start || auto_refresh) begin
                    state_d = StFetch;
                    dim_d   = dim;
                end
            end
            StFetch: begin
                rd_en   = 1'b1;
                state_d = StShift;
                phase_d = '0;
                bit_d   = '0;
                pix_d   = '0;
            end
            StShift: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        if (pix_q == LAST_PIX) begin
                            pix_d   = '0;
                            lat_d   = '0;
                            state_d = StLatch;
                        end else begin
                            // Prefetch the next pixel so it lands exactly on the boundary.
                            pix_d   = pix_q + 1'b1;
                            rd_en   = 1'b1;
                            rd_addr = pix_q + 1'b1;
                        end
                    end
                end
            end
            StLatch: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_END) begin
                    frame_done_d = 1'b1;
                    // In auto mode stay one extra cycle (lat_q == LAT_PULSE) so
                    // busy holds through the pulse before refetching.
                    if (!auto_refresh) begin
                        state_d = StIdle;
                        lat_d   = '0;
                    end
                end else if (lat_q == LAT_PULSE) begin
                    state_d = StFetch;
                    lat_d   = '0;
                    dim_d   = dim;
                end
            end
            default: state_d = StIdle;
        endcase

        // Phase 0 of any bit is always high; otherwise stay within the same bit.
        led_d = (state_d == StShift) && ((phase_d == '0) || (phase_d < thr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            bit_q        <= '0;
            pix_q        <= '0;
            lat_q        <= '0;
            dim_q        <= '0;
            led_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            pix_q        <= pix_d;
            lat_q        <= lat_d;
            dim_q        <= dim_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led        = led_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
module tb_ws2812_strip_driver;

    localparam int NUM_LEDS  = 2;
    localparam int T_BIT     = 16;
    localparam int T0H       = 4;
    localparam int T1H       = 12;
    localparam int RESET_CYC = 3600;
    localparam int AW        = 1;
    localparam int FRAME     = NUM_LEDS * 24 * T_BIT + RESET_CYC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic [2:0]    dim = '0;
    logic          start = 1'b0;
    logic          auto_refresh = 1'b0;
    logic          led, busy, frame_done;

    ws2812_strip_driver #(
        .NUM_LEDS  (NUM_LEDS),
        .T_BIT     (T_BIT),
        .T0H       (T0H),
        .T1H       (T1H),
        .RESET_CYC (RESET_CYC),
        .AW        (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .dim          (dim),
        .start        (start),
        .auto_refresh (auto_refresh),
        .led          (led),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int frames_seen = 0;
    logic [23:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Waveform decoder: rebuilds GRB words from led and checks against the scoreboard.
    bit          prev_led, prev_fd, fd_auto;
    int          hi, nbits, fbits, rise_cnt, last_rise, first_rise, fd_cyc;
    logic [23:0] word, exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_led = 1'b0;
            prev_fd  = 1'b0;
            fd_auto  = 1'b0;
            hi       = 0;
            nbits    = 0;
            fbits    = 0;
            rise_cnt = 0;
        end else begin
            if (led && !prev_led) begin
                if (rise_cnt == 0) begin
                    first_rise = cyc;
                    if (fd_auto) check_eq("auto_gap", cyc - fd_cyc, 2);
                    fd_auto = 1'b0;
                end else begin
                    check_eq("bit_period", cyc - last_rise, T_BIT);
                end
                last_rise = cyc;
                rise_cnt++;
                if (nbits == 0) begin
                    check_eq("sb_has_word", exp_q.size() > 0, 1);
                    exp_w = (exp_q.size() > 0) ? exp_q[0] : 24'h0;
                end
                hi = 0;
            end
            if (led) hi++;
            if (!led && prev_led) begin
                check_eq("bit_high", hi, exp_w[23 - nbits] ? T1H : T0H);
                word = {word[22:0], hi > T_BIT / 2};
                nbits++;
                fbits++;
                if (nbits == 24) begin
                    if (exp_q.size() > 0) check_eq("word", word, exp_q.pop_front());
                    nbits = 0;
                end
            end
            if (frame_done) begin
                check_eq("fd_width", prev_fd, 0);
                check_eq("frame_len", cyc - first_rise, FRAME);
                check_eq("frame_bits", fbits, 24 * NUM_LEDS);
                check_eq("busy_at_fd", busy, auto_refresh);
                frames_seen++;
                fbits    = 0;
                rise_cnt = 0;
                fd_cyc   = cyc;
                fd_auto  = auto_refresh;
            end
            prev_led = led;
            prev_fd  = frame_done;
        end
    end

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_frames", frames_seen, target);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gaps, n, since;

        // Reset state
        #1;
        check_eq("rst_led", led, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fd", frame_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single '1' byte, full brightness, with acceptance latency
        wr(0, 24'hFF0000);
        wr(1, 24'h000000);
        dim = 3'd0;
        exp_q.push_back(24'hFF0000);
        exp_q.push_back(24'h000000);
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("acc_busy", busy, 1);
        check_eq("acc_led", led, 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_rise", led, 1);
        wait_frames(1, 6000);
        @(negedge clk);
        check_eq("busy_after", busy, 0);

        // Dimming, dim changed after acceptance must not matter
        wr(0, 24'h80FF40);
        dim = 3'd2;
        exp_q.push_back(24'h203F10);
        exp_q.push_back(24'h000000);
        pulse_start();
        repeat (3) @(negedge clk);
        dim = 3'd0;
        wait_frames(2, 6000);

        // Start while busy is ignored
        wr(0, 24'h123456);
        wr(1, 24'hA5C3F0);
        exp_q.push_back(24'h123456);
        exp_q.push_back(24'hA5C3F0);
        pulse_start();
        repeat (300) @(negedge clk);
        pulse_start();
        wait_frames(3, 6000);
        repeat (200) @(negedge clk);
        check_eq("no_queued", frames_seen, 3);
        check_eq("idle_after_q", busy, 0);

        // Writes during a frame
        wr(0, 24'h0F0F0F);
        wr(1, 24'h111111);
        exp_q.push_back(24'h0F0F0F);
        exp_q.push_back(24'h2468AC);
        pulse_start();
        repeat (100) @(negedge clk);
        wr(1, 24'h2468AC);
        wr(0, 24'hF00F55);
        wait_frames(4, 6000);
        exp_q.push_back(24'hF00F55);
        exp_q.push_back(24'h2468AC);
        pulse_start();
        wait_frames(5, 6000);

        // Auto-refresh for three frames, cleared during the third
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(24'hF00F55);
            exp_q.push_back(24'h2468AC);
        end
        @(negedge clk);
        auto_refresh = 1'b1;
        @(posedge clk);
        #1;
        gaps  = 0;
        n     = 0;
        since = 0;
        while (n < 16000) begin
            @(negedge clk);
            n++;
            if (frames_seen >= 8) break;
            if (!busy && !frame_done) gaps++;
            if (frames_seen >= 7 && auto_refresh) begin
                since++;
                if (since >= 500) auto_refresh = 1'b0;
            end
        end
        check_eq("auto_frames", frames_seen, 8);
        check_eq("busy_gaps", gaps, 0);
        repeat (200) @(negedge clk);
        check_eq("auto_stopped", frames_seen, 8);
        check_eq("busy_after_auto", busy, 0);

        // Asynchronous reset mid-frame; buffer must survive
        exp_q.push_back(24'hF00F55);
        exp_q.push_back(24'h2468AC);
        pulse_start();
        repeat (200) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_led", led, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_fd", frame_done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(24'hF00F55);
        exp_q.push_back(24'h2468AC);
        pulse_start();
        wait_frames(9, 6000);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
